// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer: state encoding,
// counter / retry / lock-loss widths and a saturating increment helper.
package pll_seq_pkg;

    localparam int CNT_W   = 19;
    localparam int RETRY_W = 4;
    localparam int LOST_W  = 8;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_t;

    localparam logic [LOST_W-1:0] LOST_MAX = 8'hFF;

    function automatic logic [LOST_W-1:0] lost_sat_inc(input logic [LOST_W-1:0] v);
        return (v == LOST_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing a single asynchronous bit into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture; both stages clear on block reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock / release sequencer with bounded retries and FAIL state.
// Optional lock-loss event counter enabled by macro PLL_SEQ_LOCK_LOST_CNT_EN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 270000,
    parameter int MAX_RETRIES         = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pll_lock,
    input  logic              relock_req,
    output logic              pll_reset,
    output logic              sys_resetn,
    output logic [2:0]        state,
    output logic              fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOST_W-1:0] lock_lost_cnt
);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that saw lock already counts as the first stable sample.
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 2);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic               lock_s;
    seq_state_t         cur_r;
    seq_state_t         nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_nxt_s;

    sync_2ff u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_lock),
        .q      (lock_s)
    );

    // Next-state and next retry count from current state, counter and lock.
    always_comb begin
        nxt_s       = cur_r;
        retry_nxt_s = retry_r;
        case (cur_r)
            ST_RESET_PLL: begin
                if (cnt_r == HOLD_LAST) nxt_s = ST_WAIT_LOCK;
                else                    nxt_s = ST_RESET_PLL;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    nxt_s = ST_STABLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    retry_nxt_s = (retry_r == RETRY_MAX) ? retry_r : retry_r + RETRY_W'(1);
                    nxt_s       = (retry_r + RETRY_W'(1) == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
                end else begin
                    nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!lock_s)                  nxt_s = ST_WAIT_LOCK;
                else if (cnt_r == STABLE_LAST) nxt_s = ST_RUN;
                else                          nxt_s = ST_STABLE;
            end
            ST_RUN: begin
                if (!lock_s || relock_req) begin
                    nxt_s       = ST_RESET_PLL;
                    retry_nxt_s = '0;
                end else begin
                    nxt_s = ST_RUN;
                end
            end
            ST_FAIL: begin
                if (relock_req) begin
                    nxt_s       = ST_RESET_PLL;
                    retry_nxt_s = '0;
                end else begin
                    nxt_s = ST_FAIL;
                end
            end
            default: begin
                nxt_s       = ST_RESET_PLL;
                retry_nxt_s = '0;
            end
        endcase
    end

    // State, shared cycle counter, retry count and Moore outputs, all registered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_r      <= ST_RESET_PLL;
            cnt_r      <= '0;
            retry_r    <= '0;
            pll_reset  <= 1'b1;
            sys_resetn <= 1'b0;
            fail       <= 1'b0;
        end else begin
            cur_r      <= nxt_s;
            cnt_r      <= (nxt_s != cur_r) ? '0 : cnt_r + CNT_W'(1);
            retry_r    <= retry_nxt_s;
            pll_reset  <= (nxt_s == ST_RESET_PLL) || (nxt_s == ST_FAIL);
            sys_resetn <= (nxt_s == ST_RUN);
            fail       <= (nxt_s == ST_FAIL);
        end
    end

    assign state     = cur_r;
    assign retry_cnt = retry_r;

`ifdef PLL_SEQ_LOCK_LOST_CNT_EN
    logic              lost_evt_s;
    logic [LOST_W-1:0] lost_r;

    // Only a lock drop ends RUN here; a bare relock request is not counted.
    assign lost_evt_s = (cur_r == ST_RUN) && !lock_s;

    // Saturating lock-loss event counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lost_r <= '0;
        end else if (lost_evt_s) begin
            lost_r <= lost_sat_inc(lost_r);
        end else begin
            lost_r <= lost_r;
        end
    end

    assign lock_lost_cnt = lost_r;
`else
    assign lock_lost_cnt = '0;
`endif

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 16: cycles pll_reset is held high per attempt (min 2).
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before release (min 2).
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 270000: cycles waited for lock per attempt (10 ms at 27 MHz; min 2).
REQ-004 Parameter MAX_RETRIES, default 4: lock attempts before FAIL (1..15).
REQ-005 clk  input  1  27 MHz reference clock, the same net that feeds the PLL clkin; single clock domain.
REQ-006 resetn  input  1  synchronous, active-low block reset.
REQ-007 pll_lock  input  1  PLL lock output, asynchronous to clk.
REQ-008 relock_req  input  1  single-cycle pulse requesting a full PLL re-sequence.
REQ-009 pll_reset  output  1  drives the PLL reset input, active high.
REQ-010 sys_resetn  output  1  active-low reset for downstream logic (clk domain).
REQ-011 state  output  3  current state encoding.
REQ-012 fail  output  1  high while in FAIL.
REQ-013 retry_cnt  output  4  attempts consumed in the current sequence.
REQ-014 lock_lost_cnt  output  8  lock-loss event count (see Configuration).

Function
REQ-015 pll_lock SHALL pass through a 2-flop synchronizer (lock_s) before use; decisions lag pll_lock by 2 cycles.
REQ-016 States: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4; one cycle counter (width sized for the largest parameter) is shared by all states and cleared on every state change.
REQ-017 RESET_PLL: pll_reset=1; after RST_HOLD_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_reset=0; lock_s=1 -> STABLE. If LOCK_TIMEOUT_CYCLES elapse without lock: retry_cnt+1; go to FAIL if the new value equals MAX_RETRIES, else RESET_PLL.
REQ-019 STABLE: lock_s=0 -> WAIT_LOCK (timeout restarts; retry_cnt unchanged); after LOCK_STABLE_CYCLES consecutive lock_s=1 -> RUN.
REQ-020 RUN: lock_s=0 -> RESET_PLL, retry_cnt cleared; relock_req=1 -> RESET_PLL, retry_cnt cleared; both in the same cycle are handled as one event.
REQ-021 FAIL: pll_reset=1, fail=1; relock_req=1 -> RESET_PLL with retry_cnt cleared; otherwise FAIL is held.
REQ-022 relock_req SHALL be ignored in RESET_PLL, WAIT_LOCK and STABLE.
REQ-023 All outputs SHALL be registered Moore outputs: sys_resetn=1 only in RUN; the first sys_resetn=1 cycle is the cycle state==RUN.
REQ-024 When a lock drop is detected in RUN, sys_resetn SHALL fall on the same clock edge on which state leaves RUN.
REQ-025 A retry_cnt that reaches MAX_RETRIES SHALL hold until cleared; it never wraps.

Reset
REQ-026 resetn=0 at a clock edge, in any state or mid-count: state=RESET_PLL, counter=0, pll_reset=1, sys_resetn=0, fail=0, retry_cnt=0, lock_lost_cnt=0, synchronizer flops=0.
REQ-027 After resetn rises, the first RESET_PLL hold SHALL last the full RST_HOLD_CYCLES.

Configuration
REQ-028 Macro PLL_SEQ_LOCK_LOST_CNT_EN defined: lock_lost_cnt increments by 1 on each RUN exit caused by lock_s=0, saturating at 255; relock_req exits do not count.
REQ-029 PLL_SEQ_LOCK_LOST_CNT_EN undefined: no counter logic is built and lock_lost_cnt is tied to 0; the port list is unchanged.

Structure
REQ-030 Package pll_seq_pkg SHALL hold the state enum typedef, the state encodings and the width constants for the counter, retry_cnt and lock_lost_cnt.
REQ-031 The lock synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, clk domain).

Verification (bench parameters RST_HOLD=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2)
REQ-032 Cold start: resetn low 3 cycles, then high; pll_lock=1 from cycle 10 -> pll_reset high for 4 cycles, sys_resetn rises exactly 8 cycles after lock_s first samples 1; state=3.
REQ-033 Lock glitch: in STABLE, pll_lock low for 1 cycle at stable count 5 -> WAIT_LOCK, then the full 8-cycle stable count is required again; retry_cnt=0.
REQ-034 Timeout: pll_lock held 0 -> two 32-cycle WAIT_LOCK windows, retry_cnt=1 then 2, state=4, fail=1, pll_reset=1; relock_req then -> RESET_PLL, retry_cnt=0.
REQ-035 Loss in RUN: pll_lock falls with relock_req pulsed 2 cycles later -> sys_resetn falls on the edge state leaves RUN, single re-sequence, lock_lost_cnt=1 (macro on) or 0 (macro off).
REQ-036 Mid-sequence reset: resetn=0 during STABLE count 6 -> next edge shows all REQ-026 values; the RESET_PLL hold restarts at 4 cycles.
